intraloop_sched: RTL and testbench

- Sequencing controller for the intra-prediction loop (intrapred -> transformcoder -> reconstructor).
- Intra prediction of a block depends on reconstructed neighbours, so the loop is strictly serialised: exactly one block in flight.
- For each macroblock, the block issues 16 luma 4x4 blocks, then one chroma-B 8x8 block, then one chroma-R 8x8 block.
- It drives the block-number buses and start pulse, waits for the matching reconstructor feedback, runs a watchdog per block, and reports frame completion.

---
 rtl/intraloop_sched.sv | 113 +++++++++++
 tb/tb_intraloop_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/intraloop_sched.sv
// intraloop_sched: serialises the intrapred -> transformcoder -> reconstructor loop, one block in flight.
module intraloop_sched #(
    parameter int NUM_MB    = 99,
    parameter int LUMA_BLKS = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fb_luma4x4,
    input  logic        fb_chromab8x8,
    input  logic        fb_chromar8x8,
    output logic        enable,
    output logic [1:0]  chan_sel,
    output logic [31:0] mbnumber_luma4x4,
    output logic [31:0] mbnumber_chromab8x8,
    output logic [31:0] mbnumber_chromar8x8,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [7:0]  err_count
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADV, DONE} state_t;
    localparam logic [3:0]  LAST_BLK = 4'(LUMA_BLKS - 1);
    localparam logic [15:0] LAST_MB  = 16'(NUM_MB - 1);
    // a block gets exactly TIMEOUT cycles in WAIT before it is skipped
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
    state_t      state_q, state_d;
    logic [15:0] mb_q, mb_d, wd_q, wd_d;
    logic [3:0]  blk_q, blk_d;
    logic [1:0]  chan_q, chan_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fb_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mb_q    <= '0;
            wd_q    <= '0;
            blk_q   <= '0;
            chan_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mb_q    <= mb_d;
            wd_q    <= wd_d;
            blk_q   <= blk_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mb_d    = mb_q;
        wd_d    = wd_q;
        blk_d   = blk_q;
        chan_d  = chan_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        fb_hit  = chan_q == 2'd0 ? fb_luma4x4 : chan_q == 2'd1 ? fb_chromab8x8 : fb_chromar8x8;
        case (state_q)
            IDLE: if (start) begin
                mb_d    = '0;
                blk_d   = '0;
                chan_d  = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: if (fb_hit) state_d = ADV;
            else begin
                wd_d = wd_q + 16'd1;
                if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = cnt_q + {7'b0, cnt_q != 8'hff};
                    state_d = ADV;
                end
            end
            ADV: begin
                state_d = ISSUE;
                if (chan_q == 2'd0) begin
                    blk_d  = blk_q == LAST_BLK ? 4'd0 : blk_q + 4'd1;
                    chan_d = blk_q == LAST_BLK ? 2'd1 : 2'd0;
                end else if (chan_q == 2'd1) chan_d = 2'd2;
                else if (mb_q == LAST_MB) state_d = DONE;
                else begin
                    mb_d   = mb_q + 16'd1;
                    chan_d = 2'd0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enable              = state_q == ISSUE;
    assign frame_done          = state_q == DONE;
    assign busy                = state_q inside {ISSUE, WAIT, ADV};
    assign chan_sel            = chan_q;
    assign mbnumber_luma4x4    = 32'(mb_q) * 32'(LUMA_BLKS) + 32'(blk_q);
    assign mbnumber_chromab8x8 = 32'(mb_q);
    assign mbnumber_chromar8x8 = 32'(mb_q);
    assign timeout_err         = err_q;
    assign err_count           = cnt_q;
endmodule

// File: tb/tb_intraloop_sched.sv
// tb_intraloop_sched: scoreboard bench; expected issue order is queued at frame start, checked per enable.
module tb_intraloop_sched;
    localparam int NMB = 2, LB = 16, TO = 8, NBLK = NMB * (LB + 2);
    logic clk = 0, reset = 1, start = 0, fb_l = 0, fb_b = 0, fb_r = 0;
    logic enable, busy, frame_done, timeout_err;
    logic [1:0] chan_sel;
    logic [31:0] mb_l, mb_b, mb_r;
    logic [7:0] err_count;
    int cyc = 0, en_cnt = 0, done_cnt = 0, tests = 0, fails = 0;
    typedef struct {logic [1:0] ch; logic [31:0] l, b, r;} exp_t;
    exp_t sb[$];

    intraloop_sched #(.NUM_MB(NMB), .LUMA_BLKS(LB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .fb_luma4x4(fb_l), .fb_chromab8x8(fb_b), .fb_chromar8x8(fb_r),
        .enable(enable), .chan_sel(chan_sel),
        .mbnumber_luma4x4(mb_l), .mbnumber_chromab8x8(mb_b), .mbnumber_chromar8x8(mb_r),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (enable) en_cnt <= en_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: fb_l = 1;
            1: fb_b = 1;
            2: fb_r = 1;
            default: start = 1;
        endcase
        @(negedge clk);
        {fb_l, fb_b, fb_r, start} = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {enable, chan_sel, busy, frame_done, timeout_err, err_count}, 0);
        chk({tag, "_bus"}, mb_l | mb_b | mb_r, 0);
    endtask

    // sp_mode: 1 wrong-channel fb, 2 no answer, 3 fb on timeout cycle, 4 start while busy, 5 reset in WAIT
    task automatic run_frame(input int sp_idx, input int sp_mode, input int exp_err);
        exp_t x;
        int prev, gap, en0, dn0, w;
        for (int m = 0; m < NMB; m++) begin
            for (int b = 0; b < LB; b++) begin
                x.ch = 0; x.l = m * LB + b; x.b = m; x.r = m;
                sb.push_back(x);
            end
            x.ch = 1; x.l = m * LB; sb.push_back(x);
            x.ch = 2; sb.push_back(x);
        end
        en0 = en_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        start = 1;
        prev = cyc;
        gap = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < NBLK; i++) begin
            w = 0;
            while (!enable && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!enable) begin
                chk("enable_wait", 0, 1);
                sb.delete();
                return;
            end
            chk("gap", cyc - prev, gap);
            prev = cyc;
            x = sb.pop_front();
            chk("chan", chan_sel, x.ch);
            chk("luma", mb_l, x.l);
            chk("cb", mb_b, x.b);
            chk("cr", mb_r, x.r);
            chk("busy", busy, 1);
            gap = 7;
            if (i == sp_idx && sp_mode == 1) begin
                repeat (2) @(negedge clk);
                pulse((x.ch + 1) % 3);
                repeat (2) @(negedge clk);
                pulse(x.ch);
            end else if (i == sp_idx && sp_mode == 2) begin
                repeat (TO + 1) @(negedge clk);
                gap = TO + 2;
            end else if (i == sp_idx && sp_mode == 3) begin
                repeat (TO) @(negedge clk);
                pulse(x.ch);
                gap = TO + 2;
            end else if (i == sp_idx && sp_mode == 4) begin
                repeat (2) @(negedge clk);
                pulse(3);
                repeat (2) @(negedge clk);
                pulse(x.ch);
            end else if (i == sp_idx && sp_mode == 5) begin
                repeat (2) @(negedge clk);
                reset = 1;
                @(negedge clk);
                chk_idle("abort");
                reset = 0;
                repeat (5) @(negedge clk);
                chk("abort_done", done_cnt - dn0, 0);
                chk("abort_en", en_cnt - en0, i + 1);
                sb.delete();
                return;
            end else begin
                repeat (5) @(negedge clk);
                pulse(x.ch);
            end
        end
        @(negedge clk);
        chk("frame_done", frame_done, 1);
        chk("busy_done", busy, 0);
        chk("err_count", err_count, exp_err);
        chk("timeout_err", timeout_err, exp_err != 0);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("idle_done", {frame_done, busy}, 0);
        repeat (5) @(negedge clk);
        chk("en_total", en_cnt - en0, NBLK);
        chk("done_total", done_cnt - dn0, 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 0;
        run_frame(-1, 0, 0);
        run_frame(2, 1, 0);
        run_frame(16, 1, 0);
        run_frame(3, 2, 1);
        run_frame(7, 3, 0);
        run_frame(10, 4, 0);
        run_frame(34, 5, 0);
        run_frame(-1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
